matmul_feed: RTL

- Operand sequencer that sits directly upstream of the multiplication calculation stage.
- On `start`, it walks every (row, col) output coordinate of an N×N product in row-major order, with col fastest.
- For each coordinate it reads row r of A and column c of B from two on-chip operand buffers, then presents them as one valid pair per cycle with their indices.
- The calc stage therefore sees exactly N consecutive pairs per output row, ending on col = N-1.

---
 rtl/matmul_feed_pkg.sv | 18 +
 rtl/matmul_feed.sv | 120 ++++++++++++
 2 files changed

// File: rtl/matmul_feed_pkg.sv
// Shared definitions for the matmul operand sequencer: FSM encoding,
// element width and a power-of-two helper for the index-wrap logic.
package matmul_feed_pkg;

   localparam int unsigned ELEM_W = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   function automatic bit is_pow2(input int unsigned n);
      return (n != 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/matmul_feed.sv
// Operand sequencer: walks every (row, col) of an N x N product in row-major
// order, strobes the A/B operand buffers and presents one valid pair per cycle.
module matmul_feed
   import matmul_feed_pkg::*;
#(
   parameter int unsigned MUL_SIZE  = 8,
   parameter int unsigned ADDR_BITS = $clog2(MUL_SIZE)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         hold,
   output logic                         busy,
   output logic                         done,
   output logic                         a_rd_en,
   output logic [ADDR_BITS-1:0]         a_rd_addr,
   input  logic [ELEM_W*MUL_SIZE-1:0]   a_rd_data,
   output logic                         b_rd_en,
   output logic [ADDR_BITS-1:0]         b_rd_addr,
   input  logic [ELEM_W*MUL_SIZE-1:0]   b_rd_data,
   output logic                         out_valid,
   output logic [ADDR_BITS-1:0]         out_row_no,
   output logic [ELEM_W*MUL_SIZE-1:0]   out_row,
   output logic [ADDR_BITS-1:0]         out_col_no,
   output logic [ELEM_W*MUL_SIZE-1:0]   out_col
);

   // Index wrap relies on the all-ones compare, hence power-of-two N only.
   localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;
   localparam bit                   IS_POW2  = is_pow2(MUL_SIZE);

   state_e                 state_q, state_d;
   logic [ADDR_BITS-1:0]   r_q, r_d;
   logic [ADDR_BITS-1:0]   c_q, c_d;
   logic                   issue;

   logic                   out_valid_q;
   logic [ADDR_BITS-1:0]   out_row_no_q, out_row_no_d;
   logic [ADDR_BITS-1:0]   out_col_no_q, out_col_no_d;

   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      c_d     = c_q;
      issue   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_RUN;
               r_d     = '0;
               c_d     = '0;
            end
         end
         S_RUN: begin
            if (!hold) begin
               issue = 1'b1;
               if (c_q == LAST_IDX) begin
                  c_d = '0;
                  r_d = r_q + 1'b1;
                  if (r_q == LAST_IDX) begin
                     state_d = S_DRAIN;
                  end
               end else begin
                  c_d = c_q + 1'b1;
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Index outputs keep their last value while no pair is issued.
   always_comb begin
      out_row_no_d = out_row_no_q;
      out_col_no_d = out_col_no_q;
      if (issue) begin
         out_row_no_d = r_q;
         out_col_no_d = c_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         r_q          <= '0;
         c_q          <= '0;
         out_valid_q  <= 1'b0;
         out_row_no_q <= '0;
         out_col_no_q <= '0;
      end else begin
         state_q      <= state_d;
         r_q          <= r_d;
         c_q          <= c_d;
         out_valid_q  <= issue;
         out_row_no_q <= out_row_no_d;
         out_col_no_q <= out_col_no_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (IS_POW2);
      end
   end

   assign busy       = (state_q != S_IDLE);
   assign done       = (state_q == S_DONE);
   assign a_rd_en    = issue;
   assign b_rd_en    = issue;
   assign a_rd_addr  = r_q;
   assign b_rd_addr  = c_q;
   assign out_valid  = out_valid_q;
   assign out_row_no = out_row_no_q;
   assign out_col_no = out_col_no_q;
   assign out_row    = a_rd_data;
   assign out_col    = b_rd_data;

endmodule
